processor: RTL and testbench
============================

PROCESSOR -- requirements
Module: processor

Interface
REQ-001 Parameter: RESET_PC, default 0, PC value loaded at reset.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 address_imem  output  32  instruction address (= PC).
REQ-005 q_imem  input  32  instruction word, valid one rising edge after address_imem is presented.
REQ-006 ctrl_writeEnable  output  1  regfile write strobe.
REQ-007 ctrl_writeReg, ctrl_readRegA, ctrl_readRegB  output  5 each  regfile write/read indices.
REQ-008 data_writeReg  output  32  regfile write data.
REQ-009 data_readRegA, data_readRegB  input  32 each  combinational regfile read data.
REQ-010 wren  output  1  data memory write enable.
REQ-011 address_dmem  output  32  data address; data  output  32  store data; q_dmem  input  32  load data, valid one edge after address.
REQ-012 in0..in7  input  1 each  8-bit sensor sample, in0 = LSB.
REQ-013 out  output  1  registered digital output pin.
REQ-014 thermistorVoltage  output  32  registered voltage value.

Function
REQ-015 Format: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2]; imm = sign-extended [16:0]; target = zero-extended [26:0].
REQ-016 FSM states FETCH, EXEC, MEM; FETCH->EXEC always; EXEC->MEM for lw only, else EXEC->FETCH; MEM->FETCH.
REQ-017 R-type (opcode 00000): aluop 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll by shamt, 00101 sra by shamt; rd <= result; other aluop = nop.
REQ-018 addi 00101: rd <= rs + imm; 32-bit wrap-around.
REQ-019 sw 00111: mem[rs+imm] <= rd, wren high for the EXEC cycle only; lw 01000: rd <= mem[rs+imm], written in MEM.
REQ-020 j 00001: PC <= target; jal 00011: r31 <= PC+1, PC <= target; jr 00100: PC <= rd.
REQ-021 bne 00010: if rd != rs, PC <= PC+1+imm; blt 00110: if signed rd < rs, PC <= PC+1+imm; else PC <= PC+1.
REQ-022 rdin 01001: rd <= {24'b0, in7..in0}, inputs sampled in EXEC.
REQ-023 vout 01010: thermistorVoltage <= rd value; pin 01011: out <= rd value bit 0.
REQ-024 Undefined opcodes are nops: PC <= PC+1, no writes.
REQ-025 Regfile writes occur only in EXEC (or MEM for lw); ctrl_writeEnable never asserted for destination 0.
REQ-026 Read ports: readRegA = rs; readRegB = rt for R-type, rd for sw/bne/blt/jr/vout/pin.
REQ-027 PC addresses words; PC+1 wraps at 2^32.
REQ-028 wren and ctrl_writeEnable are low in FETCH.

Reset
REQ-029 While reset low: PC = RESET_PC, state FETCH, out = 0, thermistorVoltage = 0, wren = 0, ctrl_writeEnable = 0.
REQ-030 Reset asserted mid-instruction aborts it immediately; no partial write completes.
REQ-031 First fetch is at RESET_PC on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro OVF_STATUS_EN: when defined, signed overflow of add/addi/sub writes r30 = 1/2/3 respectively instead of rd; when undefined, the wrapped result goes to rd.

Verification
REQ-033 addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2 -> r3 = 2; each write on its EXEC edge, 2 cycles/instruction.
REQ-034 sw r1,4(r0); lw r4,4(r0) -> wren pulse 1 cycle at address 4, data 5; r4 = 5 after 3-cycle lw.
REQ-035 in7..in0 = 10011001 (in0=1, in3=1, in4=1, in7=1); rdin r5 -> r5 = 153.
REQ-036 vout r5; pin r1 -> thermistorVoltage = 153, out = 1; both 0 after reset.
REQ-037 bne r1,r0,2 taken skips two instructions; blt r2,r1 taken (-3 < 5); jal 10 -> r31 = PC+1, PC = 10; jr r31 returns.
REQ-038 With OVF_STATUS_EN: 0x7FFFFFFF + 1 via add -> r30 = 1, rd unchanged; without it -> rd = 0x80000000.

Source files
------------

// File: rtl/processor_if.sv
// processor_if -- instruction memory, register file and data memory
// signals shared by the core (master) and its memories (slave).
interface processor_if;
  logic [31:0] address_imem;
  logic [31:0] q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_dmem;

  modport master (
    output address_imem,
    input  q_imem,
    output ctrl_writeEnable,
    output ctrl_writeReg,
    output ctrl_readRegA,
    output ctrl_readRegB,
    output data_writeReg,
    input  data_readRegA,
    input  data_readRegB,
    output wren,
    output address_dmem,
    output data,
    input  q_dmem
  );

  modport slave (
    input  address_imem,
    output q_imem,
    input  ctrl_writeEnable,
    input  ctrl_writeReg,
    input  ctrl_readRegA,
    input  ctrl_readRegB,
    input  data_writeReg,
    output data_readRegA,
    output data_readRegB,
    input  wren,
    input  address_dmem,
    input  data,
    output q_dmem
  );
endinterface

// File: rtl/processor.sv
// processor -- multicycle FETCH/EXEC/MEM core with external regfile and memories.
// Define OVF_STATUS_EN to send signed add/addi/sub overflow codes to r30.
module processor #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  processor_if.master bus,
  input  logic        in0,
  input  logic        in1,
  input  logic        in2,
  input  logic        in3,
  input  logic        in4,
  input  logic        in5,
  input  logic        in6,
  input  logic        in7,
  output logic        out,
  output logic [31:0] thermistorVoltage
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc_inc;
  logic [4:0]  lw_rd;
  logic        out_n;
  logic [31:0] tv_n;

  logic [31:0] ir;
  logic [4:0]  opcode, rd, rs, rt, shamt, aluop;
  logic [31:0] imm, target, a, b, ea;
  logic        unused_ir;

  logic is_r, is_j, is_bne, is_jal, is_jr, is_addi;
  logic is_blt, is_sw, is_lw, is_rdin, is_vout, is_pin;

  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  logic [31:0] sum, diff, alu;
  logic        alu_ok;
`ifdef OVF_STATUS_EN
  logic [1:0]  ovf;
`endif

  assign ir        = bus.q_imem;
  assign opcode    = ir[31:27];
  assign rd        = ir[26:22];
  assign rs        = ir[21:17];
  assign rt        = ir[16:12];
  assign shamt     = ir[11:7];
  assign aluop     = ir[6:2];
  assign imm       = {{15{ir[16]}}, ir[16:0]};
  assign target    = {5'd0, ir[26:0]};
  assign unused_ir = ^ir[1:0];

  assign is_r    = opcode == 5'd0;
  assign is_j    = opcode == 5'd1;
  assign is_bne  = opcode == 5'd2;
  assign is_jal  = opcode == 5'd3;
  assign is_jr   = opcode == 5'd4;
  assign is_addi = opcode == 5'd5;
  assign is_blt  = opcode == 5'd6;
  assign is_sw   = opcode == 5'd7;
  assign is_lw   = opcode == 5'd8;
  assign is_rdin = opcode == 5'd9;
  assign is_vout = opcode == 5'd10;
  assign is_pin  = opcode == 5'd11;

  assign bus.address_imem  = pc;
  assign bus.ctrl_readRegA = rs;
  assign bus.ctrl_readRegB = is_r ? rt : rd;
  assign a = bus.data_readRegA;
  assign b = bus.data_readRegB;

  assign pc_inc           = pc + 32'd1;
  assign ea               = a + imm;
  assign bus.address_dmem = ea;
  assign bus.data         = b;
  assign sum              = a + b;
  assign diff             = a - b;

  // ALU result for R-type and addi, plus overflow code
  always_comb begin
    alu    = '0;
    alu_ok = 1'b0;
`ifdef OVF_STATUS_EN
    ovf    = 2'd0;
`endif
    if (is_addi) begin
      alu    = ea;
      alu_ok = 1'b1;
`ifdef OVF_STATUS_EN
      if (a[31] == imm[31] && ea[31] != a[31]) ovf = 2'd2;
`endif
    end else if (is_r) begin
      alu_ok = 1'b1;
      case (aluop)
        5'd0: begin
          alu = sum;
`ifdef OVF_STATUS_EN
          if (a[31] == b[31] && sum[31] != a[31]) ovf = 2'd1;
`endif
        end
        5'd1: begin
          alu = diff;
`ifdef OVF_STATUS_EN
          if (a[31] != b[31] && diff[31] != a[31]) ovf = 2'd3;
`endif
        end
        5'd2:    alu = a & b;
        5'd3:    alu = a | b;
        5'd4:    alu = a << shamt;
        5'd5:    alu = $signed(a) >>> shamt;
        default: alu_ok = 1'b0;
      endcase
    end
  end

  // next state, next PC and write strobes
  always_comb begin
    state_n = FETCH;
    pc_n    = pc;
    we      = 1'b0;
    wreg    = rd;
    wdata   = '0;
    bus.wren = 1'b0;
    out_n   = out;
    tv_n    = thermistorVoltage;
    case (state)
      FETCH: state_n = EXEC;
      EXEC: begin
        pc_n = pc_inc;
        unique case (1'b1)
          is_r, is_addi: begin
            we    = alu_ok;
            wdata = alu;
`ifdef OVF_STATUS_EN
            if (ovf != 2'd0) begin
              wreg  = 5'd30;
              wdata = {30'd0, ovf};
            end
`endif
          end
          is_sw: bus.wren = 1'b1;
          is_lw: begin
            state_n = MEM;
            pc_n    = pc;
          end
          is_j: pc_n = target;
          is_jal: begin
            we    = 1'b1;
            wreg  = 5'd31;
            wdata = pc_inc;
            pc_n  = target;
          end
          is_jr: pc_n = b;
          is_bne: if (a != b) pc_n = pc_inc + imm;
          is_blt: if ($signed(b) < $signed(a)) pc_n = pc_inc + imm;
          is_rdin: begin
            we    = 1'b1;
            wdata = {24'd0, in7, in6, in5, in4, in3, in2, in1, in0};
          end
          is_vout: tv_n = b;
          is_pin: out_n = b[0];
          default: ;
        endcase
      end
      MEM: begin
        pc_n  = pc_inc;
        we    = 1'b1;
        wreg  = lw_rd;
        wdata = bus.q_dmem;
      end
      default: state_n = FETCH;
    endcase
  end

  assign bus.ctrl_writeEnable = we && (wreg != 5'd0);
  assign bus.ctrl_writeReg    = wreg;
  assign bus.data_writeReg    = wdata;

  // architectural state; reset aborts any instruction in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= FETCH;
      pc                <= RESET_PC;
      lw_rd             <= '0;
      out               <= 1'b0;
      thermistorVoltage <= '0;
    end else begin
      state             <= state_n;
      pc                <= pc_n;
      if (state == EXEC) lw_rd <= rd;
      out               <= out_n;
      thermistorVoltage <= tv_n;
    end
  end

endmodule

// File: tb/tb_processor.sv
// tb_processor -- program table with scoreboards for regfile writes,
// data stores and fetch trace/timing, plus reset corner sequences.
module tb_processor;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] ins;
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
    logic        st;
  } vec_t;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  typedef struct {
    logic [31:0] pc;
    int          cyc;
  } tr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  sens  = 8'b1001_1001;
  logic        out;
  logic [31:0] tv;

  processor_if bus();

  processor #(.RESET_PC(32'd0)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .in0(sens[0]),
    .in1(sens[1]),
    .in2(sens[2]),
    .in3(sens[3]),
    .in4(sens[4]),
    .in5(sens[5]),
    .in6(sens[6]),
    .in7(sens[7]),
    .out(out),
    .thermistorVoltage(tv)
  );

  always #5 clock = ~clock;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] rf   [32];
  logic        rf_init = 1'b1;
  logic        mon_on  = 1'b0;
  int          cyc     = 0;
  int          n_cmp   = 0;
  int          n_bad   = 0;

  vec_t tbl [$];
  wr_t  wq  [$];
  st_t  dq  [$];
  tr_t  tq  [$];

  assign bus.data_readRegA = rf[bus.ctrl_readRegA];
  assign bus.data_readRegB = rf[bus.ctrl_readRegB];

  always @(posedge clock) begin
    bus.q_imem <= imem[bus.address_imem[5:0]];
    bus.q_dmem <= dmem[bus.address_dmem[5:0]];
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
      rf[20] <= 32'h7fff_ffff;
      rf[21] <= 32'd1;
      rf[22] <= 32'h8000_0000;
    end else begin
      if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 5'd0)
        rf[bus.ctrl_writeReg] <= bus.data_writeReg;
      if (bus.wren) dmem[bus.address_dmem[5:0]] <= bus.data;
    end
  end

  always @(posedge clock) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  logic        have_last = 1'b0;
  logic [31:0] last_pc   = '0;

  always @(negedge clock) begin
    wr_t w;
    st_t s;
    tr_t t;
    if (mon_on && reset) begin
      if (bus.ctrl_writeEnable) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL wr_extra: got r%0d=%h required no write",
                   bus.ctrl_writeReg, bus.data_writeReg);
        end else begin
          w = wq.pop_front();
          if (bus.ctrl_writeReg !== w.r || bus.data_writeReg !== w.d) begin
            n_bad++;
            $display("FAIL wr: got r%0d=%h required r%0d=%h",
                     bus.ctrl_writeReg, bus.data_writeReg, w.r, w.d);
          end
        end
      end
      if (bus.wren) begin
        n_cmp++;
        if (dq.size() == 0) begin
          n_bad++;
          $display("FAIL st_extra: got [%h]=%h required no store",
                   bus.address_dmem, bus.data);
        end else begin
          s = dq.pop_front();
          if (bus.address_dmem !== s.a || bus.data !== s.d) begin
            n_bad++;
            $display("FAIL st: got [%h]=%h required [%h]=%h",
                     bus.address_dmem, bus.data, s.a, s.d);
          end
        end
      end
      if (!have_last || bus.address_imem !== last_pc) begin
        have_last <= 1'b1;
        last_pc   <= bus.address_imem;
        if (tq.size() != 0) begin
          t = tq.pop_front();
          n_cmp++;
          if (bus.address_imem !== t.pc || cyc != t.cyc) begin
            n_bad++;
            $display("FAIL fetch: got pc=%0d at cyc %0d required pc=%0d at cyc %0d",
                     bus.address_imem, cyc, t.pc, t.cyc);
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] R(int op, int rd, int rs, int rt, int sh);
    logic [31:0] o, d, s, t, h;
    o = op; d = rd; s = rs; t = rt; h = sh;
    return {5'd0, d[4:0], s[4:0], t[4:0], h[4:0], o[4:0], 2'b00};
  endfunction

  function automatic logic [31:0] I(int op, int rd, int rs, int imm);
    logic [31:0] o, d, s, m;
    o = op; d = rd; s = rs; m = imm;
    return {o[4:0], d[4:0], s[4:0], m[16:0]};
  endfunction

  function automatic logic [31:0] J(int op, int tgt);
    logic [31:0] o, t;
    o = op; t = tgt;
    return {o[4:0], t[26:0]};
  endfunction

  function automatic vec_t mk(int addr, logic [31:0] ins, logic we,
                              int r, logic [31:0] d, logic st);
    vec_t v;
    logic [31:0] rr;
    rr     = r;
    v.addr = addr;
    v.ins  = ins;
    v.we   = we;
    v.r    = rr[4:0];
    v.d    = d;
    v.st   = st;
    return v;
  endfunction

  initial begin
    int c;
    for (int i = 0; i < 64; i++) imem[i] = '0;

    tbl.push_back(mk(0,  I(5, 1, 0, 5),       1, 1,  32'd5, 0));
    tbl.push_back(mk(1,  I(5, 2, 0, -3),      1, 2,  32'hffff_fffd, 0));
    tbl.push_back(mk(2,  R(0, 3, 1, 2, 0),    1, 3,  32'd2, 0));
    tbl.push_back(mk(3,  I(7, 1, 0, 4),       0, 0,  32'd0, 1));
    tbl.push_back(mk(4,  I(8, 4, 0, 4),       1, 4,  32'd5, 0));
    tbl.push_back(mk(5,  I(9, 5, 0, 0),       1, 5,  32'd153, 0));
    tbl.push_back(mk(6,  I(10, 5, 0, 0),      0, 0,  32'd0, 0));
    tbl.push_back(mk(7,  I(11, 1, 0, 0),      0, 0,  32'd0, 0));
    tbl.push_back(mk(8,  I(2, 1, 0, 2),       0, 0,  32'd0, 0));
    tbl.push_back(mk(11, I(6, 2, 1, 1),       0, 0,  32'd0, 0));
    tbl.push_back(mk(13, J(3, 20),            1, 31, 32'd14, 0));
    tbl.push_back(mk(20, R(5, 10, 2, 0, 1),   1, 10, 32'hffff_fffe, 0));
    tbl.push_back(mk(21, R(2, 11, 1, 2, 0),   1, 11, 32'd5, 0));
    tbl.push_back(mk(22, I(5, 0, 0, 7),       0, 0,  32'd0, 0));
    tbl.push_back(mk(23, 32'hf800_0000,       0, 0,  32'd0, 0));
    tbl.push_back(mk(24, I(2, 1, 1, 5),       0, 0,  32'd0, 0));
    tbl.push_back(mk(25, I(6, 1, 2, 5),       0, 0,  32'd0, 0));
    tbl.push_back(mk(26, R(3, 12, 1, 2, 0),   1, 12, 32'hffff_fffd, 0));
    tbl.push_back(mk(27, R(31, 13, 1, 2, 0),  0, 0,  32'd0, 0));
    tbl.push_back(mk(28, I(4, 31, 0, 0),      0, 0,  32'd0, 0));
    tbl.push_back(mk(14, R(1, 8, 1, 2, 0),    1, 8,  32'd8, 0));
    tbl.push_back(mk(15, R(4, 9, 1, 0, 3),    1, 9,  32'd40, 0));
    tbl.push_back(mk(16, J(1, 30),            0, 0,  32'd0, 0));
`ifdef OVF_STATUS_EN
    tbl.push_back(mk(30, R(0, 14, 20, 21, 0), 1, 30, 32'd1, 0));
    tbl.push_back(mk(31, I(5, 15, 20, 1),     1, 30, 32'd2, 0));
    tbl.push_back(mk(32, R(1, 16, 22, 21, 0), 1, 30, 32'd3, 0));
`else
    tbl.push_back(mk(30, R(0, 14, 20, 21, 0), 1, 14, 32'h8000_0000, 0));
    tbl.push_back(mk(31, I(5, 15, 20, 1),     1, 15, 32'h8000_0000, 0));
    tbl.push_back(mk(32, R(1, 16, 22, 21, 0), 1, 16, 32'h7fff_ffff, 0));
`endif
    tbl.push_back(mk(33, J(1, 33),            0, 0,  32'd0, 0));

    imem[9]  = I(5, 6, 0, 99);
    imem[10] = I(5, 6, 0, 98);
    imem[12] = I(5, 7, 0, 77);

    c = 0;
    foreach (tbl[i]) begin
      imem[tbl[i].addr[5:0]] = tbl[i].ins;
      tq.push_back('{pc: tbl[i].addr, cyc: c});
      if (tbl[i].we) wq.push_back('{r: tbl[i].r, d: tbl[i].d});
      if (tbl[i].st) dq.push_back('{a: 32'd4, d: 32'd5});
      c += (tbl[i].ins[31:27] == 5'd8) ? 3 : 2;
    end

    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_pc",   bus.address_imem, 32'd0);
    chk("rst_we",   32'(bus.ctrl_writeEnable), 32'd0);
    chk("rst_wren", 32'(bus.wren), 32'd0);
    chk("rst_out",  32'(out), 32'd0);
    chk("rst_tv",   tv, 32'd0);
    rf_init = 1'b0;
    mon_on  = 1'b1;
    @(posedge clock);
    #2 reset = 1'b1;

    for (int i = 0; i < 400 && tq.size() != 0; i++) @(negedge clock);
    chk("trace_drain", 32'(tq.size()), 32'd0);
    repeat (6) @(negedge clock);
    mon_on = 1'b0;

    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    chk("tv_153",   tv, 32'd153);
    chk("out_1",    32'(out), 32'd1);
    chk("r4_lw",    rf[4], 32'd5);
    chk("r6_skip",  rf[6], 32'd0);
    chk("r7_skip",  rf[7], 32'd0);

    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst2_pc",   bus.address_imem, 32'd0);
    chk("rst2_out",  32'(out), 32'd0);
    chk("rst2_tv",   tv, 32'd0);
    chk("rst2_we",   32'(bus.ctrl_writeEnable), 32'd0);
    chk("rst2_wren", 32'(bus.wren), 32'd0);

    imem[0] = I(5, 17, 0, 42);
    @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_we_pre", 32'(bus.ctrl_writeEnable), 32'd1);
    chk("abort_reg",    32'(bus.ctrl_writeReg), 32'd17);
    reset = 1'b0;
    #1;
    chk("abort_we", 32'(bus.ctrl_writeEnable), 32'd0);
    chk("abort_pc", bus.address_imem, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("abort_rf", rf[17], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
